// File: rtl/demux_seq_ctrl_pkg.sv
// rtl/demux_seq_ctrl_pkg.sv - shared state encodings, sizes and helpers for the demux request sequencer
package demux_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int CH_N  = 4;
    localparam int CNT_W = 8;

    // Saturating increment so a busy channel sticks at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_seq_ctrl_dwell_timer.sv
// rtl/demux_seq_ctrl_dwell_timer.sv - 8-bit loadable down-counter timing the PULSE and HOLD phases
module dwell_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/demux_seq_ctrl.sv
// rtl/demux_seq_ctrl.sv - glitch-safe select/strobe sequencer for the 1-to-4 demux; DEMUX_SEQ_STATS_EN adds per-channel pulse counters
module demux_seq_ctrl
    import demux_seq_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_chan,
    output logic             in_ready,
    output logic [1:0]       x,
    output logic             d,
    output logic             busy,
    output logic             done,
    input  logic             stats_clr,
    input  logic [1:0]       stat_sel,
    output logic [CNT_W-1:0] stat_cnt
);

    generate
        if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
            $error("demux_seq_ctrl: DWELL must be in 1..255");
        end
        if (GAP < 1 || GAP > 255) begin : g_bad_gap
            $error("demux_seq_ctrl: GAP must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
    localparam logic [7:0] GAP_M1   = 8'(GAP - 1);

    logic [1:0] state;
    logic       timer_zero;
    logic       timer_load;
    logic [7:0] timer_val;

    // The timer is reloaded as each timed phase begins; it sits at zero otherwise.
    assign timer_load = (state == ST_SETUP) || ((state == ST_PULSE) && timer_zero);
    assign timer_val  = (state == ST_SETUP) ? DWELL_M1 : GAP_M1;

    dwell_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    assign in_ready = (state == ST_IDLE) && !reset;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_HOLD) && timer_zero;

    // Sequencer: x only moves on IDLE->SETUP, d is high exactly while in PULSE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            x     <= 2'b00;
            d     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_SETUP;
                        x     <= in_chan;
                    end
                end
                ST_SETUP: begin
                    state <= ST_PULSE;
                    d     <= 1'b1;
                end
                ST_PULSE: begin
                    if (timer_zero) begin
                        state <= ST_HOLD;
                        d     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    d     <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEMUX_SEQ_STATS_EN
    logic [CNT_W-1:0] cnt [CH_N];

    // Count pulses per channel as each pulse starts; a clear beats a coincident increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH_N; i++) cnt[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < CH_N; i++) cnt[i] <= '0;
        end else if (state == ST_SETUP) begin
            cnt[x] <= sat_inc(cnt[x]);
        end
    end

    assign stat_cnt = cnt[stat_sel];
`else
    logic unused_stats;
    assign unused_stats = stats_clr ^ (^stat_sel);
    assign stat_cnt     = '0;
`endif

endmodule

// File: tb/tb_demux_seq_ctrl.sv
// tb/tb_demux_seq_ctrl.sv - scoreboard bench for demux_seq_ctrl (DWELL=4/GAP=1 and DWELL=1/GAP=1 instances)
module tb_demux_seq_ctrl;

    localparam int DWELL = 4;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, d, busy, done, stats_clr;
    logic [1:0] in_chan, x, stat_sel;
    logic [7:0] stat_cnt;

    logic       in_valid1, in_ready1, d1, busy1, done1;
    logic [1:0] in_chan1, x1;
    logic [7:0] stat_cnt1;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int chan;
        int t;
    } req_t;

    req_t q[$];
    req_t cur;
    bit   active   = 1'b0;
    int   plen     = 0;
    int   ready_at = -1;
    logic dprev    = 1'b0;
    logic rprev    = 1'b0;
    logic [1:0] xprev = 2'b00;
    int   mcnt[4]  = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    demux_seq_ctrl #(.DWELL(DWELL), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_chan(in_chan),
        .in_ready(in_ready), .x(x), .d(d), .busy(busy), .done(done),
        .stats_clr(stats_clr), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );

    demux_seq_ctrl #(.DWELL(1), .GAP(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_chan(in_chan1),
        .in_ready(in_ready1), .x(x1), .d(d1), .busy(busy1), .done(done1),
        .stats_clr(1'b0), .stat_sel(2'b00), .stat_cnt(stat_cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request from a posedge+#1 context; returns at posedge+#1 after its handshake edge.
    task automatic send(input int c, input bit keep);
        int n;
        in_valid = 1'b1;
        in_chan  = 2'(c);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_stats();
        int e;
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
`ifdef DEMUX_SEQ_STATS_EN
            e = mcnt[s];
`else
            e = 0;
`endif
            chk($sformatf("stat_cnt%0d", s), {24'd0, stat_cnt}, e);
        end
    endtask

    // Monitor: records handshakes as expected pulses and checks every pulse, done and ready edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                active   = 1'b0;
                dprev    = 1'b0;
                rprev    = 1'b0;
                ready_at = -1;
            end else begin
                if (in_valid && in_ready) begin
                    q.push_back('{chan: int'(in_chan), t: cyc});
                    if (mcnt[in_chan] < 255) mcnt[in_chan]++;
                end
                chk("busy", {31'd0, busy}, {31'd0, !in_ready});
                if (d && !dprev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", {31'd0, d}, 32'd0);
                    end else begin
                        cur    = q.pop_front();
                        active = 1'b1;
                        plen   = 0;
                        chk("pulse_chan", {30'd0, x}, cur.chan);
                        chk("pulse_start", cyc, cur.t + 2);
                    end
                end
                if (d) plen++;
                if (d && dprev) chk("x_stable", {30'd0, x}, {30'd0, xprev});
                if (!d && dprev) chk("pulse_len", plen, DWELL);
                if (done) begin
                    if (!active) begin
                        chk("spurious_done", {31'd0, done}, 32'd0);
                    end else begin
                        chk("done_cycle", cyc, cur.t + 1 + DWELL + GAP);
                        active   = 1'b0;
                        ready_at = cur.t + DWELL + GAP + 2;
                    end
                end
                if (in_ready && !rprev && ready_at >= 0) begin
                    chk("ready_cycle", cyc, ready_at);
                    ready_at = -1;
                end
                dprev = d;
                rprev = in_ready;
                xprev = x;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ch[4];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_chan   = 2'b00;
        stats_clr = 1'b0;
        stat_sel  = 2'b00;
        in_valid1 = 1'b0;
        in_chan1  = 2'b00;
        idle(2);

        chk("rst_d", {31'd0, d}, 0);
        chk("rst_x", {30'd0, x}, 0);
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_stat", {24'd0, stat_cnt}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;

        send(3, 1'b0);
        idle(10);

        // Reset in the middle of a pulse on channel 2.
        send(2, 1'b0);
        idle(2);
        chk("pre_rst_d", {31'd0, d}, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_d", {31'd0, d}, 0);
        chk("mid_rst_x", {30'd0, x}, 0);
        chk("mid_rst_ready", {31'd0, in_ready}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, in_ready}, 1);
        chk("post_rst_done", {31'd0, done}, 0);
        @(posedge clk); #1;
        check_stats();

        for (int c = 0; c < 4; c++) send(c, c < 3);
        idle(12);

        repeat (40) begin
            send($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if (!in_valid) idle($urandom_range(0, 3));
        end
        in_valid = 1'b0;
        idle(12);
        check_stats();

        repeat (300) send(1, 1'b1);
        in_valid = 1'b0;
        idle(12);
        check_stats();

        // Clear asserted exactly on the SETUP->PULSE edge of a new request.
        send(1, 1'b0);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        idle(10);
        check_stats();

        // DWELL=1/GAP=1 instance, in_valid held: 4-cycle period, 1-cycle pulse, done right after.
        for (int i = 0; i < 4; i++) ch[i] = $urandom_range(0, 3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("d1_pattern", {31'd0, d1}, (i % 4 == 2) ? 1 : 0);
            chk("done1_pattern", {31'd0, done1}, (i % 4 == 3) ? 1 : 0);
            chk("ready1_pattern", {31'd0, in_ready1}, (i % 4 == 0) ? 1 : 0);
            if (i >= 1) chk("x1_chan", {30'd0, x1}, ch[(i - 1) / 4]);
            if (i % 4 == 0) begin
                in_chan1  = 2'(ch[i / 4]);
                in_valid1 = 1'b1;
            end
        end
        in_valid1 = 1'b0;
        idle(4);

        chk("pending_requests", q.size(), 0);
        chk("pulse_open", {31'd0, active}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
